// File: rtl/act_share_scheduler_if.sv
// Bundle of neuron sum inputs and the activated-result output stream.
// master: neuron array + downstream consumer side; slave: the scheduler.
interface act_share_scheduler_if #(
    parameter int NUM_NEURONS = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
);
    logic [NUM_NEURONS-1:0]              sum_valid;
    logic [NUM_NEURONS*2*DATA_WIDTH-1:0] sum_data;
    logic                                act_valid;
    logic                                act_ready;
    logic [DATA_WIDTH-1:0]               act_data;
    logic [IDX_WIDTH-1:0]                act_idx;

    modport master (
        output sum_valid, sum_data, act_ready,
        input  act_valid, act_data, act_idx
    );

    modport slave (
        input  sum_valid, sum_data, act_ready,
        output act_valid, act_data, act_idx
    );
endinterface

// File: rtl/act_share_scheduler.sv
// Round-robin sharing of one truncating activation stage across neurons.
// Ports: clk/sync active-low reset, layer_clear, bus (sums in, results out),
// layer_done pulse after NUM_NEURONS accepts, sticky overflow_err.
module act_share_scheduler #(
    parameter int NUM_NEURONS = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  layer_clear,
    act_share_scheduler_if.slave  bus,
    output logic                  layer_done,
    output logic                  overflow_err
);
    localparam int SW = 2 * DATA_WIDTH;
    localparam logic [IDX_WIDTH:0]   N_EXT = (IDX_WIDTH+1)'(NUM_NEURONS);
    localparam logic [IDX_WIDTH-1:0] LAST  = IDX_WIDTH'(NUM_NEURONS - 1);

    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [SW-1:0]          slot_q [NUM_NEURONS];
    logic [SW-1:0]          slot_d [NUM_NEURONS];
    logic                   act_valid_q, act_valid_d;
    logic [DATA_WIDTH-1:0]  act_data_q, act_data_d;
    logic [IDX_WIDTH-1:0]   act_idx_q, act_idx_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   layer_done_q, layer_done_d;
    logic                   overflow_q, overflow_d;

    logic                   found;
    logic [IDX_WIDTH-1:0]   grant;
    logic [IDX_WIDTH:0]     probe;
    logic                   load;
    logic                   hs;

    // First pending index at or above ptr, wrapping to 0.
    always_comb begin
        found = 1'b0;
        grant = '0;
        probe = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            probe = {1'b0, ptr_q} + (IDX_WIDTH+1)'(k);
            if (probe >= N_EXT) begin
                probe = probe - N_EXT;
            end
            if (!found && pending_q[probe[IDX_WIDTH-1:0]]) begin
                found = 1'b1;
                grant = probe[IDX_WIDTH-1:0];
            end
        end
    end

    assign load = (!act_valid_q || bus.act_ready) && found;
    assign hs   = act_valid_q && bus.act_ready;

    always_comb begin
        pending_d    = pending_q;
        slot_d       = slot_q;
        act_valid_d  = act_valid_q;
        act_data_d   = act_data_q;
        act_idx_d    = act_idx_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        layer_done_d = 1'b0;
        overflow_d   = overflow_q;

        if (load) begin
            act_valid_d      = 1'b1;
            act_data_d       = slot_q[grant][SW-1 -: DATA_WIDTH];
            act_idx_d        = grant;
            pending_d[grant] = 1'b0;
            ptr_d            = (grant == LAST) ? '0 : grant + 1'b1;
        end else if (hs) begin
            act_valid_d = 1'b0;
        end

        // Capture after the grant clear so a same-edge refill stays pending.
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (bus.sum_valid[i]) begin
                if (pending_q[i] && !(load && grant == IDX_WIDTH'(i))) begin
                    overflow_d = 1'b1;
                end
                pending_d[i] = 1'b1;
                slot_d[i]    = bus.sum_data[i*SW +: SW];
            end
        end

        if (hs) begin
            if (cnt_q == LAST) begin
                cnt_d        = '0;
                layer_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn || layer_clear) begin
            pending_q    <= '0;
            act_valid_q  <= 1'b0;
            act_data_q   <= '0;
            act_idx_q    <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            layer_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            pending_q    <= pending_d;
            act_valid_q  <= act_valid_d;
            act_data_q   <= act_data_d;
            act_idx_q    <= act_idx_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            layer_done_q <= layer_done_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign bus.act_valid = act_valid_q;
    assign bus.act_data  = act_data_q;
    assign bus.act_idx   = act_idx_q;
    assign layer_done    = layer_done_q;
    assign overflow_err  = overflow_q;
endmodule

// File: doc/act_share_scheduler.md
Name: act_share_scheduler

Overview:
- Shares one truncating activation stage between NUM_NEURONS neuron accumulators in the ELM hidden layer.
- Each neuron posts one 2*DATA_WIDTH sum with a single-cycle valid pulse. The block buffers one sum per neuron and grants the stage round-robin.
- Results leave on a valid/ready stream tagged with the neuron index. A pulse flags completion of a full layer.

Parameters:
- NUM_NEURONS, 8, number of requesting neurons (2..64).
- DATA_WIDTH, 16, activation output width; sums are 2*DATA_WIDTH.
- IDX_WIDTH, $clog2(NUM_NEURONS), width of the neuron index.

Ports:
- s_axi_aclk  in  1  clock; all logic on rising edge.
- s_axi_aresetn  in  1  synchronous, active-low reset.
- layer_clear  in  1  synchronous clear of all layer state; same effect as reset.
- sum_valid  in  NUM_NEURONS  per-neuron one-cycle pulse; sum is present.
- sum_data  in  NUM_NEURONS*2*DATA_WIDTH  neuron i sum in bits [i*2*DATA_WIDTH +: 2*DATA_WIDTH].
- act_valid  out  1  output result valid.
- act_ready  in  1  downstream accepts.
- act_data  out  DATA_WIDTH  activated result.
- act_idx  out  IDX_WIDTH  neuron index of act_data.
- layer_done  out  1  one-cycle pulse when NUM_NEURONS results have been accepted.
- overflow_err  out  1  sticky: a sum arrived while that neuron's slot was still pending.

Behaviour:
- Reset (s_axi_aresetn=0 at an edge) or layer_clear=1 sets the following to 0:
  - all pending flags and slot registers;
  - act_valid, act_data, act_idx;
  - layer_done, overflow_err;
  - the round-robin pointer and the accept counter.
- Reset or clear mid-transfer discards in-flight data; no partial state survives. Reset has priority over clear.
- Capture: at an edge with sum_valid[i]=1, slot[i] loads sum_data slice i and pending[i] is set.
- Arbitration uses only registered pending flags. A sum never bypasses its slot.
- The output register loads when (!act_valid || act_ready) and at least one pending flag is set.
  - Grant goes to the first set pending index searching upward from ptr, wrapping NUM_NEURONS-1 -> 0.
  - On grant:
    - act_data = slot[g][2*DATA_WIDTH-1 -: DATA_WIDTH], i.e. the upper half of the sum, truncated with no rounding or saturation;
    - act_idx = g; act_valid = 1;
    - pending[g] is cleared;
    - ptr = (g+1) mod NUM_NEURONS.
- Latency: a pulse at edge t, with the output stage free, gives act_valid=1 after edge t+1 (2 cycles).
- Throughput: one result per cycle while act_ready=1 and work is pending.
- Backpressure: while act_valid && !act_ready, act_data and act_idx hold stable. No grant occurs and ptr holds.
- If act_valid && act_ready and nothing is pending, act_valid drops to 0 after the edge.
- Simultaneous events:
  - sum_valid[i] at the same edge pending[i] is granted: the new sum is captured, pending[i] stays 1, no error.
  - sum_valid[i] while pending[i]=1 and i is not granted: the new sum overwrites slot[i] and overflow_err is set. overflow_err holds until reset or clear.
- Accept counter: increments on each act_valid && act_ready edge.
  - On the edge where it would reach NUM_NEURONS, it returns to 0 and layer_done=1 for the next cycle only.
  - Counting is by handshake, not by index; duplicate indices still count.
- With no sum_valid activity, the block idles with act_valid=0 and never grants stale slots.

Test Plan:
- Reset: hold s_axi_aresetn=0 for 3 cycles with sum_valid=all ones -> act_valid, layer_done, overflow_err=0 and no pending captured. First sums accepted after release.
- Single request: neuron 3 posts 0x1234_ABCD, act_ready=1 -> 2 cycles later act_valid=1, act_data=0x1234, act_idx=3. act_valid=0 the following cycle.
- Round-robin: all 8 neurons pulse in the same cycle with sum i = {i,16'hFFFF} -> 8 consecutive results, idx 0..7, data 0..7. layer_done pulses once, in the cycle after the 8th handshake.
- Backpressure: 2 pending, act_ready=0 for 5 cycles -> act_data/act_idx stable and no idx change. On act_ready=1, results flow back to back.
- Simultaneous grant+capture: neuron 5 pulses at the edge it is granted -> no overflow_err. Neuron 5 is serviced again on a later grant, with the second sum.
- Overflow and clear: act_ready=0, neuron 2 pulses twice -> overflow_err=1 and the second sum is delivered. layer_clear=1 for 1 cycle -> all outputs 0 and the counter restarts (8 new accepts needed for layer_done).
